// File: rtl/switch_debounce.sv
// -----------------------------------------------------------------------------
// switch_debounce
//
// Conditions up to WIDTH asynchronous DIP-switch / push-button inputs for use
// by synchronous control logic. Each bit goes through a two-flop synchronizer.
// The bit is then sampled once per prescaler tick. A new level is accepted
// only after STABLE_CNT consecutive tick samples differ from the current
// level. Accepted changes show up as clean levels, one-cycle rise/fall pulses,
// and a change event that is held until the consumer acknowledges it.
//
// Parameters
//   WIDTH       number of switch inputs
//   TICK_DIV    clocks per sample tick (>= 2)
//   STABLE_CNT  consecutive differing samples needed to accept a level (>= 1)
//
// Ports
//   clk        in   1      system clock
//   rst        in   1      synchronous active-high reset
//   sw_in      in   WIDTH  raw asynchronous switch inputs
//   sw_out     out  WIDTH  debounced levels
//   rise       out  WIDTH  one-cycle pulse per bit on an accepted 0->1
//   fall       out  WIDTH  one-cycle pulse per bit on an accepted 1->0
//   evt_valid  out  1      change event pending
//   evt_data   out  WIDTH  sw_out value captured at the latest change
//   evt_ovf    out  1      a change arrived while an event was still pending
//   evt_ack    in   1      consumer acknowledges the pending event
// -----------------------------------------------------------------------------
module switch_debounce #(
   parameter int WIDTH      = 8,
   parameter int TICK_DIV   = 50000,
   parameter int STABLE_CNT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] sw_in,
   output logic [WIDTH-1:0] sw_out,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             evt_valid,
   output logic [WIDTH-1:0] evt_data,
   output logic             evt_ovf,
   input  logic             evt_ack
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int CW = (STABLE_CNT > 0) ? $clog2(STABLE_CNT + 1) : 1;
   localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

   typedef enum logic {
      EVT_IDLE = 1'b0,
      EVT_PEND = 1'b1
   } evt_state_t;

   logic [WIDTH-1:0]         s1;
   logic [WIDTH-1:0]         s2;
   logic [PW-1:0]            pre_cnt;
   logic                     tick;
   logic [WIDTH-1:0][CW-1:0] db_cnt;
   logic [WIDTH-1:0][CW-1:0] db_cnt_nxt;
   logic [WIDTH-1:0]         accept;
   logic                     chg;
   logic [WIDTH-1:0]         sw_nxt;
   evt_state_t               evt_state;
   evt_state_t               evt_state_nxt;
   logic [WIDTH-1:0]         evt_data_nxt;
   logic                     evt_ovf_nxt;

   // Two-flop synchronizer. Nothing downstream looks at s1.
   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would collapse s1/s2 into one stage.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= sw_in;
         s2 <= s1;
      end
   end

   // Sample-tick prescaler. The tick is high during the last count of each period.
   assign tick = (pre_cnt == DIV_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PW'(1);
      end
   end

   // Per-bit debounce. A sample that matches the current level restarts
   // the run. The STABLE_CNT-th differing sample flips the level.
   // NOTE: every always_comb output gets a default before any branch;
   // a path that leaves one unassigned would infer a latch.
   always_comb begin
      db_cnt_nxt = db_cnt;
      accept     = '0;
      if (tick) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (s2[i] == sw_out[i]) begin
               db_cnt_nxt[i] = '0;
            end else if (db_cnt[i] == CNT_LAST) begin
               db_cnt_nxt[i] = '0;
               accept[i]     = 1'b1;
            end else begin
               db_cnt_nxt[i] = db_cnt[i] + CW'(1);
            end
         end
      end
   end

   assign chg    = |accept;
   assign sw_nxt = sw_out ^ accept;

   // Levels and edge pulses update on the same edge. The pulse polarity
   // comes from the level the bit is leaving.
   // NOTE: the debounce counter array is a set of discrete flops, not RAM.
   // It is reset so that a reset mid-count discards any partial run.
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt <= '0;
         sw_out <= '0;
         rise   <= '0;
         fall   <= '0;
      end else begin
         db_cnt <= db_cnt_nxt;
         sw_out <= sw_nxt;
         rise   <= accept & ~sw_out;
         fall   <= accept & sw_out;
      end
   end

   // Change-event handshake: state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         evt_state <= EVT_IDLE;
         evt_data  <= '0;
         evt_ovf   <= 1'b0;
      end else begin
         evt_state <= evt_state_nxt;
         evt_data  <= evt_data_nxt;
         evt_ovf   <= evt_ovf_nxt;
      end
   end

   // Change-event handshake: next state. When a change arrives in the same
   // cycle as an ack, the old event is consumed and the new one stays
   // pending, so this does not count as an overflow.
   always_comb begin
      evt_state_nxt = evt_state;
      evt_data_nxt  = evt_data;
      evt_ovf_nxt   = evt_ovf;
      case (evt_state)
         EVT_IDLE: begin
            if (chg) begin
               evt_state_nxt = EVT_PEND;
               evt_data_nxt  = sw_nxt;
               evt_ovf_nxt   = 1'b0;
            end
         end
         EVT_PEND: begin
            if (chg) begin
               evt_data_nxt = sw_nxt;
               evt_ovf_nxt  = ~evt_ack;
            end else if (evt_ack) begin
               evt_state_nxt = EVT_IDLE;
               evt_ovf_nxt   = 1'b0;
            end
         end
         default: begin
            evt_state_nxt = EVT_IDLE;
         end
      endcase
   end

   assign evt_valid = (evt_state == EVT_PEND);

endmodule

// File: tb/tb_switch_debounce.sv
// -----------------------------------------------------------------------------
// tb_switch_debounce
//
// Self-checking bench for switch_debounce (WIDTH=8, TICK_DIV=4, STABLE_CNT=3).
// A reference model tracks the sampled input history at the tick level.
// It pushes every expected rise/fall pulse into a scoreboard queue, and a
// negedge monitor pops and compares those pulses when the DUT presents them.
// The monitor also compares levels and event outputs every cycle. Directed
// phases cover reset, clean edges, bounce, overflow, ack collision and reset
// mid-count. A randomized phase follows.
// -----------------------------------------------------------------------------
module tb_switch_debounce;

   localparam int W  = 8;
   localparam int TD = 4;
   localparam int SC = 3;

   typedef struct {
      int           cyc;
      logic [W-1:0] sw;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
   } pulse_t;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] sw_in;
   logic [W-1:0] sw_out;
   logic [W-1:0] rise;
   logic [W-1:0] fall;
   logic         evt_valid;
   logic [W-1:0] evt_data;
   logic         evt_ovf;
   logic         evt_ack;

   int n_checks = 0;
   int n_fail   = 0;

   switch_debounce #(
      .WIDTH      (W),
      .TICK_DIV   (TD),
      .STABLE_CNT (SC)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sw_in     (sw_in),
      .sw_out    (sw_out),
      .rise      (rise),
      .fall      (fall),
      .evt_valid (evt_valid),
      .evt_data  (evt_data),
      .evt_ovf   (evt_ovf),
      .evt_ack   (evt_ack)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time %0t limit 400000", $time);
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model. A tick lands on every TD-th edge after reset release.
   // Each tick samples the input as it was two edges earlier. A bit's new
   // level is accepted when its last SC tick samples all differ from the
   // current level.
   // ---------------------------------------------------------------------------
   int           cyc  = 0;
   int           ecnt = 0;
   logic [W-1:0] d1   = '0;
   logic [W-1:0] d2   = '0;
   logic [W-1:0] hist[$];
   logic [W-1:0] m_sw   = '0;
   logic [W-1:0] m_data = '0;
   logic         m_valid = 1'b0;
   logic         m_ovf   = 1'b0;
   logic [W-1:0] samp;
   logic [W-1:0] acc;
   pulse_t       exp_q[$];

   always @(posedge clk) begin
      cyc++;
      if (rst) begin
         d1 = '0;
         d2 = '0;
         ecnt = 0;
         hist.delete();
         m_sw = '0;
         m_data = '0;
         m_valid = 1'b0;
         m_ovf = 1'b0;
      end else begin
         samp = d2;
         d2 = d1;
         d1 = sw_in;
         ecnt++;
         acc = '0;
         if (ecnt % TD == 0) begin
            hist.push_back(samp);
            if (hist.size() > SC) void'(hist.pop_front());
            if (hist.size() == SC) begin
               for (int i = 0; i < W; i++) begin
                  acc[i] = 1'b1;
                  foreach (hist[k]) if (hist[k][i] == m_sw[i]) acc[i] = 1'b0;
               end
            end
         end
         if (acc != '0) begin
            exp_q.push_back('{cyc: cyc, sw: m_sw ^ acc, rise: acc & ~m_sw, fall: acc & m_sw});
            m_ovf   = m_valid && !evt_ack;
            m_valid = 1'b1;
            m_sw    = m_sw ^ acc;
            m_data  = m_sw;
         end else if (m_valid && evt_ack) begin
            m_valid = 1'b0;
            m_ovf   = 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Monitor: scoreboard for pulses plus per-cycle level and event compare.
   // ---------------------------------------------------------------------------
   pulse_t got;

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         n_checks++;
         n_fail++;
         $display("FAIL pulse_missed: expected rise 0x%0h fall 0x%0h at cycle %0d, not presented by cycle %0d",
                  exp_q[0].rise, exp_q[0].fall, exp_q[0].cyc, cyc);
         void'(exp_q.pop_front());
      end
      if ((rise | fall) != '0) begin
         if (exp_q.size() == 0) begin
            check("spurious_pulse", 32'({rise, fall}), 32'd0);
         end else begin
            got = exp_q.pop_front();
            check("pulse_cycle", 32'(cyc), 32'(got.cyc));
            check("rise", 32'(rise), 32'(got.rise));
            check("fall", 32'(fall), 32'(got.fall));
            check("pulse_sw_out", 32'(sw_out), 32'(got.sw));
         end
      end
      check("sw_out", 32'(sw_out), 32'(m_sw));
      check("evt_valid", 32'(evt_valid), 32'(m_valid));
      check("evt_data", 32'(evt_data), 32'(m_data));
      check("evt_ovf", 32'(evt_ovf), 32'(m_ovf));
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic wait_sw(input logic [W-1:0] v, input int bound, input string name);
      int i = 0;
      while (sw_out !== v && i < bound) begin
         @(negedge clk);
         i++;
      end
      check(name, 32'(sw_out), 32'(v));
   endtask

   task automatic do_ack();
      evt_ack = 1'b1;
      @(negedge clk);
      evt_ack = 1'b0;
   endtask

   task automatic align_tick();
      for (int i = 0; i < TD && (ecnt % TD) != 0; i++) @(negedge clk);
   endtask

   initial begin
      int lat;
      rst     = 1'b1;
      sw_in   = 8'hFF;
      evt_ack = 1'b0;

      // Reset held 3 clk with all inputs high.
      @(negedge clk);
      check("in_reset_sw_out", 32'(sw_out), 32'h00);
      check("in_reset_pulses", 32'({rise, fall}), 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_reset_sw_out", 32'(sw_out), 32'h00);
      check("post_reset_evt_valid", 32'(evt_valid), 32'h0);
      wait_sw(8'hFF, 13, "reset_release_accept");
      check("reset_release_rise", 32'(rise), 32'hFF);

      // Clean edge 0x00 -> 0x01.
      do_ack();
      sw_in = 8'h00;
      wait_sw(8'h00, 16, "clear_to_zero");
      do_ack();
      sw_in = 8'h01;
      wait_sw(8'h01, 14, "clean_edge_accept");
      check("clean_edge_rise", 32'(rise), 32'h01);
      check("clean_edge_evt_valid", 32'(evt_valid), 32'h1);
      check("clean_edge_evt_data", 32'(evt_data), 32'h01);
      @(negedge clk);
      check("clean_edge_rise_one_clk", 32'(rise), 32'h00);
      do_ack();
      check("clean_edge_ack_drop", 32'(evt_valid), 32'h0);

      // Bounce on bit 1: toggles every 3 clk for 60 clk.
      for (int k = 0; k < 60; k++) begin
         if (k % 3 == 0) sw_in[1] = ~sw_in[1];
         @(negedge clk);
      end
      sw_in[1] = 1'b0;
      repeat (20) @(negedge clk);
      check("bounce_sw_out", 32'(sw_out), 32'h01);
      check("bounce_evt_valid", 32'(evt_valid), 32'h0);

      // Overflow: two changes without an ack.
      sw_in = 8'h00;
      wait_sw(8'h00, 14, "ovf_clear");
      do_ack();
      sw_in = 8'h04;
      wait_sw(8'h04, 14, "ovf_first");
      sw_in = 8'h0C;
      wait_sw(8'h0C, 14, "ovf_second");
      check("ovf_evt_valid", 32'(evt_valid), 32'h1);
      check("ovf_evt_data", 32'(evt_data), 32'h0C);
      check("ovf_flag", 32'(evt_ovf), 32'h1);
      do_ack();
      check("ovf_ack_valid", 32'(evt_valid), 32'h0);
      check("ovf_ack_flag", 32'(evt_ovf), 32'h0);

      // Ack collision: ack lands on the edge that accepts a fall on bit 0.
      sw_in = 8'h01;
      wait_sw(8'h01, 16, "collide_setup");
      check("collide_setup_data", 32'(evt_data), 32'h01);
      align_tick();
      sw_in = 8'h00;
      repeat (11) @(negedge clk);
      evt_ack = 1'b1;
      @(negedge clk);
      evt_ack = 1'b0;
      check("collide_fall", 32'(fall), 32'h01);
      check("collide_evt_valid", 32'(evt_valid), 32'h1);
      check("collide_evt_data", 32'(evt_data), 32'h00);
      check("collide_evt_ovf", 32'(evt_ovf), 32'h0);
      @(negedge clk);
      check("collide_fall_one_clk", 32'(fall), 32'h00);
      check("collide_valid_held", 32'(evt_valid), 32'h1);
      do_ack();

      // Reset after two ticks of a pending change on bit 7.
      align_tick();
      sw_in = 8'h80;
      repeat (8) @(negedge clk);
      check("midreset_no_early_accept", 32'(sw_out), 32'h00);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      lat = 0;
      while (sw_out[7] !== 1'b1 && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("midreset_latency", 32'(lat), 32'd12);
      do_ack();

      // Randomized phase.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 15) == 0) sw_in = 8'($urandom);
         else if ($urandom_range(0, 11) == 0) sw_in[$urandom_range(0, W-1)] ^= 1'b1;
         evt_ack = ($urandom_range(0, 7) == 0);
         rst     = ($urandom_range(0, 1499) == 0);
         @(negedge clk);
      end
      rst     = 1'b0;
      evt_ack = 1'b0;
      repeat (3) @(negedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
